mux_alu: RTL and testbench

//  32-bit integer ALU with built-in operand-B source mux for the MIPS32 datapath (execute stage).

---
 rtl/alu_pkg.sv | 21 ++
 rtl/mux_alu_if.sv | 23 ++
 rtl/alu_core.sv | 39 +++
 rtl/mux_alu.sv | 38 +++
 tb/tb_mux_alu.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the MIPS32 execute-stage ALU: data width and opcode encoding.
package alu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0011,
        ALU_NOR  = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SLT  = 4'b0110,
        ALU_SLTU = 4'b0111,
        ALU_SLL  = 4'b1000,
        ALU_SRL  = 4'b1001,
        ALU_SRA  = 4'b1010,
        ALU_LUI  = 4'b1011
    } alu_op_t;

endpackage

// File: rtl/mux_alu_if.sv
// Execute-stage ALU bus: operand/opcode inputs driven by the datapath, registered result back.
interface mux_alu_if;
    import alu_pkg::*;

    logic              ALUmux;
    logic [3:0]        ALUop;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic [DATA_W-1:0] ALUout;
    logic              ALUzero;

    modport master (
        output ALUmux, ALUop, a, b, c,
        input  ALUout, ALUzero
    );

    modport slave (
        input  ALUmux, ALUop, a, b, c,
        output ALUout, ALUzero
    );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: (op, a, opB) -> result. Unknown opcodes yield zero.
module alu_core
    import alu_pkg::*;
(
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_opb,
    output logic [DATA_W-1:0] o_result
);

    logic [4:0] w_shamt;
    logic       w_lt_signed;
    logic       w_lt_unsigned;

    assign w_shamt       = i_opb[4:0];
    assign w_lt_signed   = $signed(i_a) < $signed(i_opb);
    assign w_lt_unsigned = i_a < i_opb;

    // NOTE: o_result gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_AND:  o_result = i_a & i_opb;
            ALU_OR:   o_result = i_a | i_opb;
            ALU_ADD:  o_result = i_a + i_opb;
            ALU_SUB:  o_result = i_a - i_opb;
            ALU_NOR:  o_result = ~(i_a | i_opb);
            ALU_XOR:  o_result = i_a ^ i_opb;
            ALU_SLT:  o_result = {{(DATA_W-1){1'b0}}, w_lt_signed};
            ALU_SLTU: o_result = {{(DATA_W-1){1'b0}}, w_lt_unsigned};
            ALU_SLL:  o_result = i_a << w_shamt;
            ALU_SRL:  o_result = i_a >> w_shamt;
            ALU_SRA:  o_result = $unsigned($signed(i_a) >>> w_shamt);
            ALU_LUI:  o_result = {i_opb[15:0], 16'h0000};
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/mux_alu.sv
// MIPS32 execute-stage ALU: operand-B source mux, combinational core, registered result and zero flag.
module mux_alu
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    mux_alu_if.slave   bus
);

    logic [DATA_W-1:0] w_opb;
    logic [DATA_W-1:0] w_result;
    logic [DATA_W-1:0] r_alu_out;
    logic              r_alu_zero;

    assign w_opb = bus.ALUmux ? bus.c : bus.b;

    alu_core u_core (
        .i_op     (bus.ALUop),
        .i_a      (bus.a),
        .i_opb    (w_opb),
        .o_result (w_result)
    );

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_out  <= '0;
            r_alu_zero <= 1'b1;
        end else begin
            r_alu_out  <= w_result;
            r_alu_zero <= (w_result == '0);
        end
    end

    assign bus.ALUout  = r_alu_out;
    assign bus.ALUzero = r_alu_zero;

endmodule

// File: tb/tb_mux_alu.sv
// Scoreboard bench for mux_alu: driver queues expected results, monitor compares after each edge.
module tb_mux_alu;
    import alu_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] out;
        logic        zero;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sb_q[$];

    mux_alu_if bus();

    mux_alu u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent reference: signed compare and arithmetic shift built from bit-level rules.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ext;
        logic [4:0]  sh;
        sh  = b[4:0];
        ext = {{32{a[31]}}, a} >> sh;
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a + (~b) + 32'd1;
            4'd4:    return ~(a | b);
            4'd5:    return a ^ b;
            4'd6:    return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
            4'd7:    return {31'd0, a < b};
            4'd8:    return a << sh;
            4'd9:    return a >> sh;
            4'd10:   return ext[31:0];
            4'd11:   return {b[15:0], 16'h0};
            default: return 32'd0;
        endcase
    endfunction

    task automatic issue(input logic rst, input logic [3:0] op, input logic mux,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] exp_out, input string name);
        exp_t e;
        @(negedge clk);
        rst_n      = rst;
        bus.ALUop  = op;
        bus.ALUmux = mux;
        bus.a      = a;
        bus.b      = b;
        bus.c      = c;
        e.name = name;
        e.out  = exp_out;
        e.zero = (exp_out == 32'd0);
        sb_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check(e.name, bus.ALUout, e.out);
                check({e.name, "_zero"}, {31'd0, bus.ALUzero}, {31'd0, e.zero});
            end
        end
    end

    initial begin : driver
        logic [31:0] sa;
        logic [31:0] sb;
        logic [3:0]  sop;
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        bus.ALUop  = 4'd0;
        bus.ALUmux = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        bus.c      = '0;

        // Reset for two edges, then release with ADD 1+1.
        issue(1'b0, ALU_ADD, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, "rst_edge0");
        issue(1'b0, ALU_ADD, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, "rst_edge1");
        issue(1'b1, ALU_ADD, 1'b0, 32'd1, 32'd1, 32'd0, 32'd2, "add_1_1");

        // Arithmetic and logic directed vectors.
        issue(1'b1, ALU_ADD, 1'b0, 32'h23456789, 32'h34567891, 32'h0, 32'h579be01a, "add");
        issue(1'b1, ALU_SUB, 1'b0, 32'h23456789, 32'h34567891, 32'h0, 32'heeeeeef8, "sub");
        issue(1'b1, ALU_ADD, 1'b0, 32'hffffffff, 32'hffffffff, 32'h0, 32'hfffffffe, "add_ovf");
        issue(1'b1, ALU_SUB, 1'b0, 32'hffffffff, 32'hffffffff, 32'h0, 32'h00000000, "sub_eq");
        issue(1'b1, ALU_AND, 1'b0, 32'h23456789, 32'h34567891, 32'h0, 32'h20446081, "and");
        issue(1'b1, ALU_OR,  1'b0, 32'h23456789, 32'h34567891, 32'h0, 32'h37577f99, "or");
        issue(1'b1, ALU_XOR, 1'b0, 32'h23456789, 32'h34567891, 32'h0, 32'h17131f18, "xor");
        issue(1'b1, ALU_NOR, 1'b0, 32'h23456789, 32'h34567891, 32'h0, 32'hc8a88066, "nor");

        // Operand-B source mux; the unused source carries junk.
        issue(1'b1, ALU_ADD, 1'b1, 32'd5, 32'hffffffff, 32'h00000010, 32'h00000015, "mux_c");
        issue(1'b1, ALU_ADD, 1'b0, 32'd5, 32'hffffffff, 32'h00000010, 32'h00000004, "mux_b");

        // Compare, shift and LUI boundaries.
        issue(1'b1, ALU_SLT,  1'b0, 32'h80000000, 32'h00000001, 32'h0, 32'd1, "slt");
        issue(1'b1, ALU_SLTU, 1'b0, 32'h80000000, 32'h00000001, 32'h0, 32'd0, "sltu");
        issue(1'b1, ALU_SRA,  1'b1, 32'h80000000, 32'h0, 32'h00000024, 32'hf8000000, "sra_c");
        issue(1'b1, ALU_SRL,  1'b0, 32'h80000000, 32'h00000024, 32'h0, 32'h08000000, "srl");
        issue(1'b1, ALU_SLL,  1'b0, 32'h00000001, 32'hffffffff, 32'h0, 32'h80000000, "sll_31");
        issue(1'b1, ALU_LUI,  1'b0, 32'hdeadbeef, 32'h00001234, 32'h0, 32'h12340000, "lui");
        issue(1'b1, 4'b1100,  1'b0, 32'h23456789, 32'h34567891, 32'h0, 32'd0, "op_undef");
        issue(1'b1, 4'b1111,  1'b0, 32'hffffffff, 32'hffffffff, 32'h0, 32'd0, "op_undef_f");

        // Inputs changed mid-cycle must not reach the outputs before the next edge.
        issue(1'b1, ALU_SUB, 1'b0, 32'd100, 32'd1, 32'h0, 32'd99, "lat_sub");
        @(posedge clk);
        #3;
        bus.ALUop = ALU_AND;
        bus.a     = 32'd7;
        bus.b     = 32'd0;
        #1;
        check("lat_hold_out", bus.ALUout, 32'd99);
        check("lat_hold_zero", {31'd0, bus.ALUzero}, 32'd0);

        // Reset asserted in the middle of a SUB stream.
        issue(1'b1, ALU_SUB, 1'b0, 32'd10, 32'd3, 32'h0, 32'd7, "stream_sub0");
        issue(1'b0, ALU_SUB, 1'b0, 32'd10, 32'd3, 32'h0, 32'd0, "stream_rst");
        issue(1'b1, ALU_SUB, 1'b0, 32'd10, 32'd3, 32'h0, 32'd7, "stream_sub1");

        // Sweep all opcodes (plus one undefined) against the reference model.
        sa = 32'h23456789;
        sb = 32'h34567891;
        for (int i = 0; i < 10000; i++) begin
            sop = 4'(i % 13);
            issue(1'b1, sop, 1'b0, sa, sb, ~sb, model(sop, sa, sb), $sformatf("sweep%0d", i));
            sa = sa + 32'h23456789;
            sb = sb + 32'h34567891;
        end

        for (int i = 0; i < 8 && sb_q.size() != 0; i++) @(posedge clk);
        #2;
        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
